// File: rtl/diag_collector_if.sv
// Handshake bundle between the diagonal dispatcher, the collector and the writeback stage.
// master = dispatcher/writeback side, slave = collector.
interface diag_collector_if #(
  parameter int unsigned DATA_W = 32
);
  logic              diag_valid;
  logic [2:0]        diag_idx;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic [DATA_W-1:0] d4;
  logic              in_ready;
  logic [DATA_W-1:0] row0;
  logic [DATA_W-1:0] row1;
  logic [DATA_W-1:0] row2;
  logic [DATA_W-1:0] row3;
  logic [1:0]        row_idx;
  logic              out_valid;
  logic              out_ready;
  logic              tile_done;
  logic              err;

  modport master (
    output diag_valid, diag_idx, d1, d2, d3, d4, out_ready,
    input  in_ready, row0, row1, row2, row3, row_idx, out_valid, tile_done, err
  );

  modport slave (
    input  diag_valid, diag_idx, d1, d2, d3, d4, out_ready,
    output in_ready, row0, row1, row2, row3, row_idx, out_valid, tile_done, err
  );
endinterface

// File: rtl/diag_collector.sv
// De-skews the seven anti-diagonals of a 4x4 tile into a row-major buffer,
// then streams the tile out one row per handshake while stalling the input side.
module diag_collector #(
  parameter int unsigned DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  diag_collector_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t                         state_q, state_n;
  logic [2:0]                     exp_q, exp_n;
  logic [1:0]                     rptr_q, rptr_n;
  logic [3:0][3:0][DATA_W-1:0]    mem_q, mem_n;
  logic [3:0][DATA_W-1:0]         row_q, row_n;
  logic [1:0]                     ridx_q, ridx_n;
  logic                           ov_q, ov_n;
  logic                           td_q, td_n;
  logic                           err_q, err_n;

  logic [3:0][DATA_W-1:0]         lane;
  logic                           in_ready;
  logic                           accept;
  logic                           wr;
  logic                           load;
  logic [1:0]                     off;
  logic [2:0]                     nact;
  logic [1:0]                     r2, c2;

  assign lane     = {bus.d4, bus.d3, bus.d2, bus.d1};
  assign in_ready = (state_q != S_DRAIN);
  assign accept   = bus.diag_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      exp_q   <= 3'd1;
      rptr_q  <= '0;
      mem_q   <= '0;
      row_q   <= '0;
      ridx_q  <= '0;
      ov_q    <= 1'b0;
      td_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      exp_q   <= exp_n;
      rptr_q  <= rptr_n;
      mem_q   <= mem_n;
      row_q   <= row_n;
      ridx_q  <= ridx_n;
      ov_q    <= ov_n;
      td_q    <= td_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    exp_n   = exp_q;
    rptr_n  = rptr_q;
    mem_n   = mem_q;
    row_n   = row_q;
    ridx_n  = ridx_q;
    ov_n    = ov_q;
    td_n    = 1'b0;
    err_n   = err_q;
    wr      = 1'b0;
    load    = 1'b0;
    r2      = '0;
    c2      = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.diag_idx == 3'd1) begin
            wr      = 1'b1;
            exp_n   = 3'd2;
            state_n = S_COLLECT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (bus.diag_idx == exp_q) begin
            wr    = 1'b1;
            exp_n = exp_q + 3'd1;
            if (bus.diag_idx == 3'd7) begin
              state_n = S_DRAIN;
              rptr_n  = '0;
              load    = 1'b1;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (ov_q && bus.out_ready) begin
          if (rptr_q == 2'd3) begin
            ov_n    = 1'b0;
            td_n    = 1'b1;
            state_n = S_IDLE;
            exp_n   = 3'd1;
            rptr_n  = '0;
          end else begin
            rptr_n = rptr_q + 2'd1;
            load   = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Diagonal k, lane j (0-based): row = j + max(0, k-4), col = k-1-row; only k or 8-k lanes carry data.
    off  = (bus.diag_idx > 3'd4) ? 2'(bus.diag_idx - 3'd4) : 2'd0;
    nact = (bus.diag_idx > 3'd4) ? 3'(4'd8 - {1'b0, bus.diag_idx}) : bus.diag_idx;
    for (int unsigned j = 0; j < 4; j++) begin
      if (wr && (3'(j) < nact)) begin
        r2 = 2'(j) + off;
        c2 = bus.diag_idx[1:0] - 2'd1 - r2;
        mem_n[r2][c2] = lane[j];
      end
    end

    // Row registers load from the post-write buffer so the diag-7 beat can present row 0 immediately.
    if (load) begin
      row_n  = mem_n[rptr_n];
      ridx_n = rptr_n;
      ov_n   = 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.row0      = row_q[0];
  assign bus.row1      = row_q[1];
  assign bus.row2      = row_q[2];
  assign bus.row3      = row_q[3];
  assign bus.row_idx   = ridx_q;
  assign bus.out_valid = ov_q;
  assign bus.tile_done = td_q;
  assign bus.err       = err_q;

endmodule
